// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, field constants, FSM states and xtime helper
package aes_pkg;

    localparam int NCOL = 4;
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef logic [15:0][7:0] state_t;
    typedef logic [3:0][7:0] col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } dec_mc_state_t;

    // Multiply by x in GF(2^8), folding the x^8 term back with GF_POLY
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mod_dec_column.sv
// rtl/mod_dec_column.sv - combinational InvMixColumns on one 4-byte column
module mod_dec_column
    import aes_pkg::*;
(
    input  col_t col_in,
    output col_t col_out
);

    logic [3:0][7:0] m9, mb, md, me;

    // Build the 09/0b/0d/0e multiples of each row byte from x2/x4/x8 chains
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            logic [7:0] x2, x4, x8;
            x2 = xtime(col_in[r]);
            x4 = xtime(x2);
            x8 = xtime(x4);
            m9[r] = x8 ^ col_in[r];
            mb[r] = x8 ^ x2 ^ col_in[r];
            md[r] = x8 ^ x4 ^ col_in[r];
            me[r] = x8 ^ x4 ^ x2;
        end
    end

    assign col_out[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign col_out[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    assign col_out[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    assign col_out[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

endmodule

// File: rtl/mod_dec_multiplicator.sv
// rtl/mod_dec_multiplicator.sv - column-serial AES InvMixColumns, optional MOD_DEC_LAST_ROUND_EN bypass
module mod_dec_multiplicator
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [127:0] i_data,
`ifdef MOD_DEC_LAST_ROUND_EN
    input  logic         i_last,
`endif
    output logic         o_valid,
    input  logic         o_ready,
    output logic [127:0] o_data,
    output logic         busy
);

    dec_mc_state_t state;
    logic [1:0]    col;
    state_t        in_q;
    state_t        out_q;
    col_t          col_in;
    col_t          col_tf;
    col_t          col_res;
    logic [3:0]    base;

`ifdef MOD_DEC_LAST_ROUND_EN
    logic          last_q;
`endif

    assign base   = {col, 2'b00};
    assign col_in = in_q[base +: 4];

    mod_dec_column u_column (
        .col_in  (col_in),
        .col_out (col_tf)
    );

`ifdef MOD_DEC_LAST_ROUND_EN
    // Final decryption round skips InvMixColumns but keeps the same timing
    assign col_res = last_q ? col_in : col_tf;
`else
    assign col_res = col_tf;
`endif

    // Accept in IDLE, or in DONE only once the held result is being taken
    assign i_ready = rst && ((state == IDLE) || ((state == DONE) && o_ready));
    assign busy    = (state == CALC);
    assign o_data  = out_q;

    // Control FSM: latch block, write one result column per edge, hold until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            col     <= 2'd0;
            in_q    <= '0;
            out_q   <= '0;
            o_valid <= 1'b0;
`ifdef MOD_DEC_LAST_ROUND_EN
            last_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        in_q  <= i_data;
`ifdef MOD_DEC_LAST_ROUND_EN
                        last_q <= i_last;
`endif
                        col   <= 2'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    out_q[base +: 4] <= col_res;
                    col <= col + 2'd1;
                    if (col == 2'(NCOL - 1)) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        if (i_valid) begin
                            in_q  <= i_data;
`ifdef MOD_DEC_LAST_ROUND_EN
                            last_q <= i_last;
`endif
                            col   <= 2'd0;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_dec_multiplicator.sv
// tb/tb_mod_dec_multiplicator.sv - randomized self-checking bench for mod_dec_multiplicator
module tb_mod_dec_multiplicator;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [127:0] i_data;
    logic         i_last;
    logic         o_valid;
    logic         o_ready;
    logic [127:0] o_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_dec_multiplicator dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
`ifdef MOD_DEC_LAST_ROUND_EN
        .i_last  (i_last),
`endif
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
        logic [7:0] coef [4];
        logic [127:0] r = '0;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(coef[k], s[8*(4*c + (row + k) % 4) +: 8]);
                r[8*(4*c + row) +: 8] = acc;
            end
        return r;
    endfunction

    // Columns written as r0..r3 byte strings, packed into the DUT's byte layout
    function automatic logic [127:0] pack(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0] cs [4];
        logic [127:0] r = '0;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[8*(4*c + row) +: 8] = cs[c][8*(3 - row) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one block on the acceptance edge, then scramble i_data
    task automatic issue(input logic [127:0] d, input logic last);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_data  = rnd128();
        i_last  = $urandom_range(0, 1);
    endtask

    // Count edges from acceptance to o_valid and check the held result
    task automatic await_result(input string tag, input logic [127:0] exp);
        int lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk({tag, "_data"}, o_data, exp);
    endtask

    task automatic drain(input string tag);
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        chk({tag, "_drained"}, {127'd0, o_valid}, 128'd0);
    endtask

    task automatic run_block(input string tag, input logic [127:0] d, input logic last,
                             input logic [127:0] exp);
        chk({tag, "_iready"}, {127'd0, i_ready}, 128'd1);
        issue(d, last);
        await_result(tag, exp);
        drain(tag);
    endtask

    logic [127:0] fips_in, fips_out, held, nxt;

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0; o_ready = 1'b0;
        fips_in  = pack(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
        fips_out = pack(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);

        #1;
        chk("rst_ovalid", {127'd0, o_valid}, 128'd0);
        chk("rst_odata", o_data, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_iready", {127'd0, i_ready}, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;

        run_block("fips", fips_in, 1'b0, fips_out);
        run_block("rt", pack(32'h4d7ebdf8, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hd5d5d7d6), 1'b0,
                  pack(32'h2d26314c, 32'hd4d4d4d5, 32'h2d26314c, 32'hd4d4d4d5));
        run_block("zero", 128'd0, 1'b0, 128'd0);
        run_block("ones", {128{1'b1}}, 1'b0, {128{1'b1}});

        for (int n = 0; n < 12; n++) begin
            logic [127:0] d = rnd128();
            run_block("rand", d, 1'b0, ref_inv_mix(d));
        end

`ifdef MOD_DEC_LAST_ROUND_EN
        run_block("last", fips_in, 1'b1, fips_in);
        for (int n = 0; n < 4; n++) begin
            logic [127:0] d = rnd128();
            logic         l = 1'($urandom_range(0, 1));
            run_block("rand_last", d, l, l ? d : ref_inv_mix(d));
        end
`endif

        // Backpressure: result held while i_valid is pending and o_ready is low
        held = rnd128();
        nxt  = rnd128();
        issue(held, 1'b0);
        await_result("bp_first", ref_inv_mix(held));
        i_valid = 1'b1;
        i_data  = nxt;
        i_last  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", o_data, ref_inv_mix(held));
            chk("bp_hold_valid", {127'd0, o_valid}, 128'd1);
            chk("bp_hold_iready", {127'd0, i_ready}, 128'd0);
        end
        o_ready = 1'b1;
        #1;
        chk("bp_iready_follow", {127'd0, i_ready}, 128'd1);
        @(posedge clk); #1;
        o_ready = 1'b0;
        i_valid = 1'b0;
        i_data  = rnd128();
        chk("bp_b2b_ovalid", {127'd0, o_valid}, 128'd0);
        chk("bp_b2b_busy", {127'd0, busy}, 128'd1);
        await_result("bp_second", ref_inv_mix(nxt));
        drain("bp_second");

        // Reset after the col=2 edge drops the block in flight
        issue(rnd128(), 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_ovalid", {127'd0, o_valid}, 128'd0);
        chk("midrst_odata", o_data, 128'd0);
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_iready", {127'd0, i_ready}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        run_block("post_rst", fips_in, 1'b0, fips_out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_dec_multiplicator.md
Name: mod_dec_multiplicator

Overview:
- Computes AES InvMixColumns on a 128-bit state for the decryption datapath.
- It is the inverse of mod_enc_multiplicator and is used in every decryption round except the last.
- Column-serial: processes one 32-bit column per clock, with a valid/ready handshake on both input and output.
- Holds its result until the downstream stage (AddRoundKey / next round) accepts it.

Parameters:
- NCOL, 4, number of state columns; fixed by AES and not to be overridden.
- GF_POLY, 8'h1B, reduction term for x^8 (the field polynomial is 0x11B).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  i_data is valid.
- i_ready  out  1  block can accept i_data this cycle.
- i_data  in  128  state; byte (row r, col c) at i_data[8*(4c+r) +: 8].
- o_valid  out  1  o_data holds a completed result.
- o_ready  in  1  downstream accepts o_data.
- o_data  out  128  InvMixColumns(i_data), same byte layout as i_data.
- busy  out  1  high in CALC.

Behaviour:
- Async reset (rst=0):
  - State goes to IDLE; column counter col=0.
  - o_data=0, o_valid=0, busy=0. i_ready=0 while rst is low.
  - A reset mid-CALC or in DONE drops the block in flight with no partial output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - i_ready=1.
  - On i_valid: latch i_data into the input register, col<=0, go to CALC.
- CALC:
  - i_ready=0, busy=1.
  - Each edge writes result column col into o_data, then col<=col+1.
  - After the col=3 edge: go to DONE and set o_valid<=1.
- Latency: o_valid rises on the 4th rising edge after the acceptance edge.
- DONE:
  - o_valid=1; o_data is stable until the handshake completes.
  - i_ready = o_ready (combinational).
  - o_ready & i_valid: latch the new block, go to CALC, o_valid<=0. This is back-to-back with no bubble.
  - o_ready & !i_valid: go to IDLE, o_valid<=0.
  - !o_ready: hold, and ignore i_valid.
- o_data columns not yet written in CALC keep their previous values. They are not observable because o_valid=0.
- Column math, with inputs a0..a3 (rows 0..3) and all arithmetic in GF(2^8) mod 0x11B, '+' = XOR:
  - b0 = 0e·a0 + 0b·a1 + 0d·a2 + 09·a3
  - b1 = 09·a0 + 0e·a1 + 0b·a2 + 0d·a3
  - b2 = 0d·a0 + 09·a1 + 0e·a2 + 0b·a3
  - b3 = 0b·a0 + 0d·a1 + 09·a2 + 0e·a3
- Multiplies are built from xtime chains (x2, x4, x8), not integer multiplication. All intermediates are 8 bits wide.
- The input register is the only source for computation, so i_data may change freely after acceptance.

Optional Feature:
- MOD_DEC_LAST_ROUND_EN defined:
  - Adds input port i_last (1 bit), sampled with the input handshake.
  - If latched i_last=1, columns are copied through unchanged; this is the final decryption round, which has no InvMixColumns.
  - Latency and handshake are identical, so the pipeline timing is uniform across rounds.
- Undefined: the port is absent and every block is transformed.

Decomposition:
- Package aes_pkg holds:
  - typedef state_t, packed [15:0][7:0];
  - typedef col_t, packed [3:0][7:0];
  - GF_POLY, NCOL;
  - the FSM enum dec_mc_state_t {IDLE, CALC, DONE}.
- One combinational sub-module, mod_dec_column: col_t in, col_t out, with an internal xtime function in aes_pkg.
- mod_dec_multiplicator instantiates mod_dec_column once and muxes the input column by col.

Test Plan:
- FIPS-197 column vectors: columns {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6} (bytes r0..r3) -> {db135345, f20a225c, 01010101, c6c6c6c6}. o_valid must rise exactly 4 edges after acceptance.
- Round-trip: column 4d7ebdf8 -> 2d26314c, and d5d5d7d6 -> d4d4d4d5.
- Backpressure: hold o_ready=0 for 10 cycles in DONE while i_valid=1.
  - o_data and o_valid must be stable and i_ready=0.
  - When o_ready rises together with i_valid, the next block is accepted on the same edge, and its result appears 4 edges later.
- Reset mid-CALC: pull rst low after col=2. o_valid=0 and o_data=0 immediately; after release, i_ready=1 and a fresh block gives the correct result.
- All-zero state -> all-zero output. An all-ff column -> ffffffff (0e^0b^0d^09 = 01).
- MOD_DEC_LAST_ROUND_EN defined: i_last=1 with 8e4da1bc... -> output equals the input, with the same 4-cycle latency; i_last=0 gives the transform results above.
